// File: rtl/mips_pkg.sv
// Shared MIPS-32 encodings: opcodes, ALU/mux selects and
// multicycle control state codes.
package mips_pkg;

   localparam logic [5:0] R_TYPE     = 6'b000000;
   localparam logic [5:0] LOAD_WORD  = 6'b100011;
   localparam logic [5:0] STORE_WORD = 6'b101011;
   localparam logic [5:0] BRANCH_EQ  = 6'b000100;
   localparam logic [5:0] JUMP       = 6'b000010;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_REG     = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_RWB    = 4'd7,
      S_BEQ    = 4'd8,
      S_JUMP   = 4'd9,
      S_HALT   = 4'd10
   } state_t;

endpackage

// File: rtl/multi_cycle_control_if.sv
// Control <-> datapath bundle for the multicycle MIPS core.
// master = control unit, slave = datapath/memory side.
interface multi_cycle_control_if;

   logic [5:0]  opcode;
   logic        mem_ready;
   logic        pcwrite;
   logic        pcwritecond;
   logic        iord;
   logic        memread;
   logic        memwrite;
   logic        irwrite;
   logic        memtoreg;
   logic        regdst;
   logic        regwrite;
   logic        alusrca;
   logic [1:0]  alusrcb;
   logic [1:0]  aluop;
   logic [1:0]  pcsource;
   logic        illegal;
   logic [3:0]  state;
   logic [31:0] retired;

   modport master (
      input  opcode, mem_ready,
      output pcwrite, pcwritecond, iord, memread, memwrite,
      output irwrite, memtoreg, regdst, regwrite, alusrca,
      output alusrcb, aluop, pcsource, illegal, state, retired
   );

   modport slave (
      output opcode, mem_ready,
      input  pcwrite, pcwritecond, iord, memread, memwrite,
      input  irwrite, memtoreg, regdst, regwrite, alusrca,
      input  alusrcb, aluop, pcsource, illegal, state, retired
   );

endinterface

// File: rtl/multi_cycle_control.sv
// Main control FSM of the multicycle MIPS-32 datapath: sequences
// fetch/decode/execute/memory/writeback and counts retirements.
module multi_cycle_control #(
   parameter bit HALT_ON_ILLEGAL = 1'b1
) (
   input logic                  clk,
   input logic                  rst,
   multi_cycle_control_if.master bus
);
   import mips_pkg::*;

   state_t      cur;
   state_t      nxt;
   logic        retire;
   logic        ill_pulse;
   logic        illegal_q;
   logic [31:0] retired_q;

   always_comb begin
      nxt       = S_FETCH;
      retire    = 1'b0;
      ill_pulse = 1'b0;
      unique case (cur)
         S_FETCH:  nxt = bus.mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (bus.opcode)
               LOAD_WORD, STORE_WORD: nxt = S_MEMADR;
               R_TYPE:                nxt = S_EXEC;
               BRANCH_EQ:             nxt = S_BEQ;
               JUMP:                  nxt = S_JUMP;
               default: begin
                  if (HALT_ON_ILLEGAL) begin
                     nxt = S_HALT;
                  end else begin
                     nxt       = S_FETCH;
                     retire    = 1'b1;
                     ill_pulse = 1'b1;
                  end
               end
            endcase
         end
         S_MEMADR: begin
            if (bus.opcode == STORE_WORD)     nxt = S_MEMWR;
            else if (bus.opcode == LOAD_WORD) nxt = S_MEMRD;
            else                              nxt = S_FETCH;
         end
         S_MEMRD:  nxt = bus.mem_ready ? S_MEMWB : S_MEMRD;
         S_MEMWB: begin
            nxt    = S_FETCH;
            retire = 1'b1;
         end
         S_MEMWR: begin
            nxt    = bus.mem_ready ? S_FETCH : S_MEMWR;
            retire = bus.mem_ready;
         end
         S_EXEC:   nxt = S_RWB;
         S_RWB, S_BEQ, S_JUMP: begin
            nxt    = S_FETCH;
            retire = 1'b1;
         end
         S_HALT:   nxt = S_HALT;
         default:  nxt = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur       <= S_FETCH;
         retired_q <= '0;
         illegal_q <= 1'b0;
      end else begin
         cur       <= nxt;
         illegal_q <= (nxt == S_HALT) || ill_pulse;
         if (retire) retired_q <= retired_q + 32'd1;
      end
   end

   // Enables are gated by rst so an in-flight access dies at once.
   always_comb begin
      bus.pcwrite     = 1'b0;
      bus.pcwritecond = 1'b0;
      bus.iord        = 1'b0;
      bus.memread     = 1'b0;
      bus.memwrite    = 1'b0;
      bus.irwrite     = 1'b0;
      bus.memtoreg    = 1'b0;
      bus.regdst      = 1'b0;
      bus.regwrite    = 1'b0;
      bus.alusrca     = 1'b0;
      bus.alusrcb     = SRCB_REG;
      bus.aluop       = ALU_ADD;
      bus.pcsource    = PCSRC_ALU;
      unique case (cur)
         S_FETCH: begin
            bus.memread = 1'b1;
            bus.alusrcb = SRCB_FOUR;
            bus.irwrite = bus.mem_ready;
            bus.pcwrite = bus.mem_ready;
         end
         S_DECODE: bus.alusrcb = SRCB_IMM_SH2;
         S_MEMADR: begin
            bus.alusrca = 1'b1;
            bus.alusrcb = SRCB_IMM;
         end
         S_MEMRD: begin
            bus.memread = 1'b1;
            bus.iord    = 1'b1;
         end
         S_MEMWB: begin
            bus.regwrite = 1'b1;
            bus.memtoreg = 1'b1;
         end
         S_MEMWR: begin
            bus.memwrite = 1'b1;
            bus.iord     = 1'b1;
         end
         S_EXEC: begin
            bus.alusrca = 1'b1;
            bus.aluop   = ALU_FUNCT;
         end
         S_RWB: begin
            bus.regwrite = 1'b1;
            bus.regdst   = 1'b1;
         end
         S_BEQ: begin
            bus.alusrca     = 1'b1;
            bus.aluop       = ALU_SUB;
            bus.pcwritecond = 1'b1;
            bus.pcsource    = PCSRC_ALUOUT;
         end
         S_JUMP: begin
            bus.pcwrite  = 1'b1;
            bus.pcsource = PCSRC_JUMP;
         end
         default: ;
      endcase
      if (rst) begin
         bus.pcwrite     = 1'b0;
         bus.pcwritecond = 1'b0;
         bus.irwrite     = 1'b0;
         bus.regwrite    = 1'b0;
         bus.memwrite    = 1'b0;
         bus.memread     = 1'b0;
      end
   end

   assign bus.state   = cur;
   assign bus.illegal = illegal_q;
   assign bus.retired = retired_q;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Bench for multi_cycle_control: directed table on the halting
// variant, random run of the NOP variant against a sequence model.
module tb_multi_cycle_control;

   logic clk = 1'b0;
   logic rst_a;
   logic rst_b;

   multi_cycle_control_if bus_h ();
   multi_cycle_control_if bus_n ();

   multi_cycle_control #(.HALT_ON_ILLEGAL(1'b1)) u_halt (
      .clk (clk),
      .rst (rst_a),
      .bus (bus_h.master)
   );

   multi_cycle_control #(.HALT_ON_ILLEGAL(1'b0)) u_nop (
      .clk (clk),
      .rst (rst_b),
      .bus (bus_n.master)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   logic [15:0] vec_h;
   logic [15:0] vec_n;

   assign vec_h = {bus_h.pcwrite, bus_h.pcwritecond, bus_h.iord,
                   bus_h.memread, bus_h.memwrite, bus_h.irwrite,
                   bus_h.memtoreg, bus_h.regdst, bus_h.regwrite,
                   bus_h.alusrca, bus_h.alusrcb, bus_h.aluop,
                   bus_h.pcsource};
   assign vec_n = {bus_n.pcwrite, bus_n.pcwritecond, bus_n.iord,
                   bus_n.memread, bus_n.memwrite, bus_n.irwrite,
                   bus_n.memtoreg, bus_n.regdst, bus_n.regwrite,
                   bus_n.alusrca, bus_n.alusrcb, bus_n.aluop,
                   bus_n.pcsource};

   typedef struct {
      logic [5:0] op;
      logic       rdy;
      int         st;
      int         ret;
   } vec_t;

   vec_t tbl[$];

   // Control word expected for each state, straight from the state table.
   function automatic logic [15:0] exp_out(input int st,
                                           input logic rdy,
                                           input logic r);
      logic pw, pwc, io, mr, mw, irw, m2r, rd, rw, sa;
      logic [1:0] sb, ao, ps;
      {pw, pwc, io, mr, mw, irw, m2r, rd, rw, sa} = '0;
      sb = 2'b00;
      ao = 2'b00;
      ps = 2'b00;
      case (st)
         0: begin
            mr  = !r;
            sb  = 2'b01;
            irw = rdy && !r;
            pw  = rdy && !r;
         end
         1: sb = 2'b11;
         2: begin sa = 1'b1; sb = 2'b10; end
         3: begin mr = 1'b1; io = 1'b1; end
         4: begin rw = 1'b1; m2r = 1'b1; end
         5: begin mw = 1'b1; io = 1'b1; end
         6: begin sa = 1'b1; ao = 2'b10; end
         7: begin rw = 1'b1; rd = 1'b1; end
         8: begin sa = 1'b1; ao = 2'b01; pwc = 1'b1; ps = 2'b01; end
         9: begin pw = 1'b1; ps = 2'b10; end
         default: ;
      endcase
      return {pw, pwc, io, mr, mw, irw, m2r, rd, rw, sa, sb, ao, ps};
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic [5:0] op, input logic rdy);
      bus_h.opcode    = op;
      bus_h.mem_ready = rdy;
      bus_n.opcode    = op;
      bus_n.mem_ready = rdy;
   endtask

   task automatic add(input logic [5:0] op, input logic rdy,
                      input int st, input int ret);
      vec_t v;
      v.op  = op;
      v.rdy = rdy;
      v.st  = st;
      v.ret = ret;
      tbl.push_back(v);
   endtask

   // Apply inputs at the falling edge, check the halting DUT, clock once.
   task automatic step_h(input logic [5:0] op, input logic rdy,
                         input int st, input int ret);
      drive(op, rdy);
      #1;
      chk("h_state", {28'd0, bus_h.state}, st);
      chk("h_ctrl", {16'd0, vec_h}, {16'd0, exp_out(st, rdy, 1'b0)});
      chk("h_retired", bus_h.retired, ret);
      chk("h_illegal", {31'd0, bus_h.illegal}, {31'd0, st == 10});
      @(negedge clk);
   endtask

   // Instruction-level model of the NOP variant.
   int          m_state;
   int          m_seq[$];
   logic [31:0] m_ret;
   logic        m_ill;

   task automatic model_step(input logic [5:0] op, input logic rdy);
      m_ill = 1'b0;
      if ((m_state == 0 || m_state == 3 || m_state == 5) && !rdy) return;
      if (m_state == 0) begin
         m_seq.delete();
         m_seq.push_back(1);
         case (op)
            6'h23: begin
               m_seq.push_back(2); m_seq.push_back(3); m_seq.push_back(4);
            end
            6'h2b: begin m_seq.push_back(2); m_seq.push_back(5); end
            6'h00: begin m_seq.push_back(6); m_seq.push_back(7); end
            6'h04: m_seq.push_back(8);
            6'h02: m_seq.push_back(9);
            default: ;
         endcase
         m_state = m_seq.pop_front();
      end else if (m_seq.size() != 0) begin
         m_state = m_seq.pop_front();
      end else begin
         if (m_state == 1) m_ill = 1'b1;
         m_state = 0;
         m_ret   = m_ret + 32'd1;
      end
   endtask

   logic [5:0] cur_op;
   logic       rdy_r;
   logic [5:0] legal_ops [5];

   initial begin
      legal_ops[0] = 6'h23;
      legal_ops[1] = 6'h2b;
      legal_ops[2] = 6'h00;
      legal_ops[3] = 6'h04;
      legal_ops[4] = 6'h02;

      // lw, sw with a 3-cycle memory stall, R, beq, j, fetch stall, illegal
      add(6'h23, 1, 0, 0); add(6'h23, 1, 1, 0); add(6'h23, 1, 2, 0);
      add(6'h23, 1, 3, 0); add(6'h23, 1, 4, 0);
      add(6'h2b, 1, 0, 1); add(6'h2b, 1, 1, 1); add(6'h2b, 1, 2, 1);
      add(6'h2b, 0, 5, 1); add(6'h2b, 0, 5, 1); add(6'h2b, 0, 5, 1);
      add(6'h2b, 1, 5, 1);
      add(6'h00, 1, 0, 2); add(6'h00, 1, 1, 2); add(6'h00, 1, 6, 2);
      add(6'h00, 1, 7, 2);
      add(6'h04, 1, 0, 3); add(6'h04, 1, 1, 3); add(6'h04, 1, 8, 3);
      add(6'h02, 1, 0, 4); add(6'h02, 1, 1, 4); add(6'h02, 1, 9, 4);
      add(6'h00, 0, 0, 5); add(6'h00, 0, 0, 5); add(6'h00, 1, 0, 5);
      add(6'h00, 1, 1, 5); add(6'h00, 1, 6, 5); add(6'h00, 1, 7, 5);
      add(6'h3f, 1, 0, 6); add(6'h3f, 1, 1, 6); add(6'h3f, 1, 10, 6);
      add(6'h3f, 0, 10, 6); add(6'h3f, 1, 10, 6);

      rst_a = 1'b1;
      rst_b = 1'b1;
      drive(6'h00, 1'b1);
      @(negedge clk);
      @(negedge clk);
      chk("rst_state", {28'd0, bus_h.state}, 0);
      chk("rst_ctrl", {16'd0, vec_h}, {16'd0, exp_out(0, 1'b1, 1'b1)});
      chk("rst_retired", bus_h.retired, 0);
      chk("rst_illegal", {31'd0, bus_h.illegal}, 0);
      rst_a = 1'b0;
      rst_b = 1'b0;

      for (int i = 0; i < tbl.size(); i++)
         step_h(tbl[i].op, tbl[i].rdy, tbl[i].st, tbl[i].ret);

      // Reset out of HALT
      #2 rst_a = 1'b1;
      #1;
      chk("halt_rst_state", {28'd0, bus_h.state}, 0);
      chk("halt_rst_illegal", {31'd0, bus_h.illegal}, 0);
      chk("halt_rst_ctrl", {16'd0, vec_h}, {16'd0, exp_out(0, 1'b1, 1'b1)});
      @(negedge clk);
      rst_a = 1'b0;

      // j, then reset in the middle of a stalled lw read
      step_h(6'h02, 1, 0, 0); step_h(6'h02, 1, 1, 0); step_h(6'h02, 1, 9, 0);
      step_h(6'h23, 1, 0, 1); step_h(6'h23, 1, 1, 1); step_h(6'h23, 1, 2, 1);
      step_h(6'h23, 0, 3, 1); step_h(6'h23, 0, 3, 1);
      #2 rst_a = 1'b1;
      #1;
      chk("memrd_rst_state", {28'd0, bus_h.state}, 0);
      chk("memrd_rst_memread", {31'd0, bus_h.memread}, 0);
      chk("memrd_rst_retired", bus_h.retired, 0);
      @(negedge clk);
      rst_a = 1'b0;
      step_h(6'h23, 1, 0, 0); step_h(6'h23, 1, 1, 0); step_h(6'h23, 1, 2, 0);
      step_h(6'h23, 1, 3, 0); step_h(6'h23, 1, 4, 0); step_h(6'h23, 1, 0, 1);

      // NOP variant: illegal pulse and retirement
      rst_b = 1'b1;
      @(negedge clk);
      rst_b = 1'b0;
      drive(6'h3f, 1'b1);
      @(negedge clk);
      chk("nop_ill_decode", {28'd0, bus_n.state}, 1);
      @(negedge clk);
      chk("nop_ill_state", {28'd0, bus_n.state}, 0);
      chk("nop_ill_pulse", {31'd0, bus_n.illegal}, 1);
      chk("nop_ill_retired", bus_n.retired, 1);
      drive(6'h00, 1'b0);
      @(negedge clk);
      chk("nop_ill_clear", {31'd0, bus_n.illegal}, 0);
      chk("nop_ill_hold", {28'd0, bus_n.state}, 0);

      // Random run of the NOP variant against the model
      rst_b = 1'b1;
      @(negedge clk);
      rst_b   = 1'b0;
      m_state = 0;
      m_ret   = '0;
      m_ill   = 1'b0;
      m_seq.delete();
      cur_op  = 6'h00;
      for (int i = 0; i < 3000; i++) begin
         if (m_state == 0) begin
            if ($urandom_range(0, 5) == 5) cur_op = 6'($urandom);
            else cur_op = legal_ops[$urandom_range(0, 4)];
         end
         rdy_r = ($urandom_range(0, 3) != 0);
         drive(cur_op, rdy_r);
         #1;
         chk("rnd_state", {28'd0, bus_n.state}, m_state);
         chk("rnd_ctrl", {16'd0, vec_n},
             {16'd0, exp_out(m_state, rdy_r, 1'b0)});
         chk("rnd_retired", bus_n.retired, m_ret);
         chk("rnd_illegal", {31'd0, bus_n.illegal}, {31'd0, m_ill});
         @(posedge clk);
         model_step(cur_op, rdy_r);
         @(negedge clk);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
